param_down_timer: RTL and testbench

Parameterized loadable down-counter/timer that sits alongside the parameterized up-counters. The up-counters free-run from zero toward a terminal value. This block is loaded with a start value and counts down to zero. It raises a one-cycle `done` pulse at zero, with optional automatic reload for periodic operation. A start/busy/done handshake lets a controller launch a timed interval and learn when it expires.

---
 rtl/timer_pkg.sv | 12 +
 rtl/param_down_timer_if.sv | 25 ++
 rtl/tick_divider.sv | 38 +++
 rtl/param_down_timer.sv | 105 ++++++++++
 tb/tb_param_down_timer.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the timer family: state encoding of the loadable down-timer.
package timer_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/param_down_timer_if.sv
// Control/status bundle between a sequencing controller (master) and the down-timer (slave).
interface param_down_timer_if #(
    parameter int N = 4
);

    logic         start;
    logic [N-1:0] load_val;
    logic         reload;
    logic         en;
    logic         abort;
    logic [N-1:0] count;
    logic         busy;
    logic         done;

    modport master (
        output start, load_val, reload, en, abort,
        input  count, busy, done
    );

    modport slave (
        input  start, load_val, reload, en, abort,
        output count, busy, done
    );

endinterface

// File: rtl/tick_divider.sv
// Clock prescaler: emits one tick per DIV enabled clocks; clr restarts the phase at zero.
module tick_divider #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    generate
        if (DIV <= 1) begin : g_pass
            logic unused_sigs;
            assign unused_sigs = clk ^ rst;
            assign tick = en & ~clr;
        end else begin : g_div
            localparam int W = $clog2(DIV);
            localparam logic [W-1:0] LAST = W'(DIV - 1);

            logic [W-1:0] pre;

            always_ff @(posedge clk) begin
                if (rst) begin
                    pre <= '0;
                end else if (clr) begin
                    pre <= '0;
                end else if (en) begin
                    pre <= (pre == LAST) ? '0 : pre + W'(1);
                end
            end

            // A tick coinciding with a restart belongs to the abandoned interval.
            assign tick = en & ~clr & (pre == LAST);
        end
    endgenerate

endmodule

// File: rtl/param_down_timer.sv
// Loadable down-timer with start/busy/done handshake, optional auto-reload and prescaler.
//
// state  | meaning
// S_IDLE | waiting for start (count holds last value)
// S_RUN  | counting down, busy high
// S_DONE | expired, count held at 0 until next start
module param_down_timer
    import timer_pkg::*;
#(
    parameter int N   = 4,
    parameter int DIV = 1
) (
    input logic                clk,
    input logic                rst,
    param_down_timer_if.slave  bus
);

    state_t       state_q, state_n;
    logic [N-1:0] count_q, count_n;
    logic [N-1:0] stored_q, stored_n;
    logic         rflag_q, rflag_n;
    logic         busy_q, busy_n;
    logic         done_q, done_n;
    logic         div_en;
    logic         tick;

    assign div_en = bus.en & (state_q == S_RUN);

    tick_divider #(
        .DIV (DIV)
    ) u_tick_divider (
        .clk  (clk),
        .rst  (rst),
        .clr  (bus.start),
        .en   (div_en),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            stored_q <= '0;
            rflag_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_n;
            count_q  <= count_n;
            stored_q <= stored_n;
            rflag_q  <= rflag_n;
            busy_q   <= busy_n;
            done_q   <= done_n;
        end
    end

    always_comb begin
        state_n  = state_q;
        count_n  = count_q;
        stored_n = stored_q;
        rflag_n  = rflag_q;
        done_n   = 1'b0;

        if (bus.start) begin
            count_n  = bus.load_val;
            stored_n = bus.load_val;
            rflag_n  = bus.reload;
            state_n  = S_RUN;
        end else begin
            unique case (state_q)
                S_RUN: begin
                    if (bus.abort) begin
                        state_n = S_IDLE;
                    end else if (tick) begin
                        if (count_q > N'(1)) begin
                            count_n = count_q - N'(1);
                        end else begin
                            // Counts of 0 and 1 both expire here, so load_val=0 acts as 1.
                            done_n = 1'b1;
                            if (rflag_q) begin
                                count_n = stored_q;
                            end else begin
                                count_n = '0;
                                state_n = S_DONE;
                            end
                        end
                    end
                end
                S_IDLE, S_DONE: begin
                    state_n = state_q;
                end
                default: begin
                    state_n = S_IDLE;
                end
            endcase
        end

        busy_n = (state_n == S_RUN);
    end

    assign bus.count = count_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;

endmodule

// File: tb/tb_param_down_timer.sv
// Directed, table-driven bench for param_down_timer at DIV=1 and DIV=3.
module tb_param_down_timer;

    typedef struct {
        logic       start;
        logic [3:0] lv;
        logic       rl;
        logic       en;
        logic       ab;
        logic [3:0] c;
        logic       b;
        logic       d;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    param_down_timer_if #(.N(4)) bus1 ();
    param_down_timer_if #(.N(4)) bus3 ();

    param_down_timer #(.N(4), .DIV(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    param_down_timer #(.N(4), .DIV(3)) u_dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic s, input logic [3:0] lv, input logic rl, input logic en,
                       input logic ab, input logic [3:0] c, input logic b, input logic d);
        vec_t v;
        v.start = s; v.lv = lv; v.rl = rl; v.en = en; v.ab = ab;
        v.c = c; v.b = b; v.d = d;
        vecs.push_back(v);
    endtask

    task automatic check1(input string tag, input logic [3:0] c, input logic b, input logic d);
        check({tag, " count"}, 32'(bus1.count), 32'(c));
        check({tag, " busy"},  32'(bus1.busy),  32'(b));
        check({tag, " done"},  32'(bus1.done),  32'(d));
    endtask

    initial begin
        int exp_c3[7]   = '{2, 2, 2, 1, 1, 1, 0};
        int exp_cen[8]  = '{4, 3, 2, 2, 2, 2, 1, 0};
        int en_seq[8]   = '{1, 1, 1, 0, 0, 0, 1, 1};

        // load 5, one-shot
        add(1, 5, 0, 1, 0, 5, 1, 0);
        add(0, 0, 0, 1, 0, 4, 1, 0);
        add(0, 0, 0, 1, 0, 3, 1, 0);
        add(0, 0, 0, 1, 0, 2, 1, 0);
        add(0, 0, 0, 1, 0, 1, 1, 0);
        add(0, 0, 0, 1, 0, 0, 0, 1);
        add(0, 0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 1, 1, 0, 0, 0);
        // reload 3 for four periods, then abort
        add(1, 3, 1, 1, 0, 3, 1, 0);
        for (int p = 0; p < 4; p++) begin
            add(0, 0, 0, 1, 0, 2, 1, 0);
            add(0, 0, 0, 1, 0, 1, 1, 0);
            add(0, 0, 0, 1, 0, 3, 1, 1);
        end
        add(0, 0, 0, 1, 1, 3, 0, 0);
        add(0, 0, 0, 1, 0, 3, 0, 0);
        add(0, 0, 0, 1, 0, 3, 0, 0);
        // load 0 expires on first tick
        add(1, 0, 0, 1, 0, 0, 1, 0);
        add(0, 0, 0, 1, 0, 0, 0, 1);
        // restart mid-count
        add(1, 6, 0, 1, 0, 6, 1, 0);
        add(0, 0, 0, 1, 0, 5, 1, 0);
        add(0, 0, 0, 1, 0, 4, 1, 0);
        add(1, 6, 0, 1, 0, 6, 1, 0);
        add(0, 0, 0, 1, 0, 5, 1, 0);
        add(0, 0, 0, 1, 0, 4, 1, 0);
        add(0, 0, 0, 1, 0, 3, 1, 0);
        add(0, 0, 0, 1, 0, 2, 1, 0);
        add(0, 0, 0, 1, 0, 1, 1, 0);
        add(0, 0, 0, 1, 0, 0, 0, 1);
        // start beats abort and en=0
        add(1, 2, 0, 0, 1, 2, 1, 0);
        add(0, 0, 0, 1, 0, 1, 1, 0);
        add(0, 0, 0, 1, 0, 0, 0, 1);
        // reload with stored 0: done every tick
        add(1, 0, 1, 1, 0, 0, 1, 0);
        add(0, 0, 0, 1, 0, 0, 1, 1);
        add(0, 0, 0, 1, 0, 0, 1, 1);
        add(0, 0, 0, 1, 1, 0, 0, 0);

        bus1.start = 0; bus1.load_val = '0; bus1.reload = 0; bus1.en = 0; bus1.abort = 0;
        bus3.start = 0; bus3.load_val = '0; bus3.reload = 0; bus3.en = 0; bus3.abort = 0;
        rst = 1'b1;
        step();
        step();
        check1("reset1", 0, 0, 0);
        check("reset3 count", 32'(bus3.count), 0);
        check("reset3 busy",  32'(bus3.busy),  0);
        check("reset3 done",  32'(bus3.done),  0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            bus1.start    = vecs[i].start;
            bus1.load_val = vecs[i].lv;
            bus1.reload   = vecs[i].rl;
            bus1.en       = vecs[i].en;
            bus1.abort    = vecs[i].ab;
            step();
            check1($sformatf("vec%0d", i), vecs[i].c, vecs[i].b, vecs[i].d);
        end
        bus1.start = 0; bus1.abort = 0; bus1.en = 0;

        // DIV=3, load 2: count moves every third clock, done after 6 clocks
        for (int k = 0; k < 7; k++) begin
            bus3.start    = (k == 0);
            bus3.load_val = 4'd2;
            bus3.reload   = 1'b0;
            bus3.en       = 1'b1;
            step();
            check($sformatf("div3 k%0d count", k), 32'(bus3.count), 32'(exp_c3[k]));
            check($sformatf("div3 k%0d busy", k),  32'(bus3.busy),  32'(k < 6));
            check($sformatf("div3 k%0d done", k),  32'(bus3.done),  32'(k == 6));
        end
        bus3.start = 0;
        step();
        check("div3 after done", 32'(bus3.done), 0);

        // load 4, en low for three cycles after two ticks
        for (int k = 0; k < 8; k++) begin
            bus1.start    = (k == 0);
            bus1.load_val = 4'd4;
            bus1.reload   = 1'b0;
            bus1.en       = en_seq[k][0];
            step();
            check1($sformatf("enhold k%0d", k), 4'(exp_cen[k]), k < 7, k == 7);
        end

        // synchronous reset mid-run while count=3
        bus1.start = 1; bus1.load_val = 4'd5; bus1.en = 1;
        step();
        bus1.start = 0;
        step();
        step();
        check1("prerst", 3, 1, 0);
        rst = 1'b1;
        step();
        check1("midrst", 0, 0, 0);
        rst = 1'b0;
        step();
        check1("postrst", 0, 0, 0);
        step();
        check1("postrst2", 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
